// File: rtl/writeback_stage.sv
// writeback_stage: registers MEM results, assembles vector loads from 32-bit beats and pulses register-file write enables
module writeback_stage #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int DEST_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_m,
  input  logic                    wreg_m,
  input  logic                    rmem_m,
  input  logic                    VF_m,
  input  logic [DEST_W-1:0]       R_V_dest_m,
  input  logic [LANES*LANE_W-1:0] ALURes_m,
  input  logic [LANE_W-1:0]       mem_rdata,
  input  logic                    mem_rvalid,
  output logic [LANES*LANE_W-1:0] ResRV2,
  output logic [DEST_W-1:0]       R_V_dest3,
  output logic                    VF3,
  output logic                    EnReg,
  output logic                    EnVec,
  output logic                    stall
);
  localparam int VW = LANES * LANE_W;
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_S, WAIT_V} state_t;
  state_t            state_q, state_d;
  logic              wreg_q, vf_q;
  logic [DEST_W-1:0] dest_q, c_dest;
  logic [CW-1:0]     cnt_q;
  logic [VW-1:0]     buf_q, asm_w, res_d;
  logic              accept, alu_c, ld_s, ld_v, done, c_wreg, c_vf;
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (valid_m && rmem_m) ? (VF_m ? WAIT_V : WAIT_S) : IDLE;
      WAIT_S:  state_d = mem_rvalid ? IDLE : WAIT_S;
      WAIT_V:  state_d = ld_v ? IDLE : WAIT_V;
      default: state_d = IDLE;
    endcase
  end
  // ALU results commit straight from the inputs; loads commit from the held instruction fields
  always_comb begin
    stall  = state_q != IDLE;
    accept = state_q == IDLE && valid_m;
    alu_c  = accept && !rmem_m;
    ld_s   = state_q == WAIT_S && mem_rvalid;
    ld_v   = state_q == WAIT_V && mem_rvalid && cnt_q == CW'(LANES - 1);
    done   = alu_c || ld_s || ld_v;
    c_wreg = alu_c ? wreg_m : wreg_q;
    c_vf   = alu_c ? VF_m : vf_q;
    c_dest = alu_c ? R_V_dest_m : dest_q;
    asm_w  = buf_q;
    asm_w[int'(cnt_q) * LANE_W +: LANE_W] = mem_rdata;
    res_d  = alu_c ? ALURes_m : ld_s ? VW'(mem_rdata) : asm_w;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ResRV2    <= '0;
      R_V_dest3 <= '0;
      VF3       <= 1'b0;
      EnReg     <= 1'b0;
      EnVec     <= 1'b0;
      wreg_q    <= 1'b0;
      vf_q      <= 1'b0;
      dest_q    <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
    end else begin
      EnReg <= done && c_wreg && !c_vf;
      EnVec <= done && c_wreg && c_vf;
      if (done) begin
        ResRV2    <= res_d;
        R_V_dest3 <= c_dest;
        VF3       <= c_vf;
      end
      if (accept) begin
        wreg_q <= wreg_m;
        vf_q   <= VF_m;
        dest_q <= R_V_dest_m;
        cnt_q  <= '0;
      end
      if (state_q == WAIT_V && mem_rvalid) begin
        buf_q <= asm_w;
        cnt_q <= ld_v ? '0 : cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed scenarios plus randomized traffic against a queue-based reference model
module tb_writeback_stage;
  logic         clk = 1'b0, rst = 1'b1;
  logic         valid_m = 0, wreg_m = 0, rmem_m = 0, VF_m = 0, mem_rvalid = 0;
  logic [3:0]   R_V_dest_m = 0;
  logic [127:0] ALURes_m = 0;
  logic [31:0]  mem_rdata = 0;
  logic [127:0] ResRV2;
  logic [3:0]   R_V_dest3;
  logic         VF3, EnReg, EnVec, stall;
  int checks = 0, failures = 0;

  writeback_stage dut (
    .clk(clk), .rst(rst), .valid_m(valid_m), .wreg_m(wreg_m), .rmem_m(rmem_m), .VF_m(VF_m),
    .R_V_dest_m(R_V_dest_m), .ALURes_m(ALURes_m), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .ResRV2(ResRV2), .R_V_dest3(R_V_dest3), .VF3(VF3), .EnReg(EnReg), .EnVec(EnVec), .stall(stall)
  );

  always #5 clk = ~clk;

  // reference model: a pending load collects beats in a queue until it has enough to commit
  bit           m_pend, m_wreg, m_vf;
  logic [3:0]   m_dest;
  logic [31:0]  m_q[$];
  logic [127:0] e_res;
  logic [3:0]   e_dest;
  logic         e_vf, e_enreg, e_envec, e_stall;

  task automatic commit(input logic [127:0] d, input logic w, input logic v, input logic [3:0] r);
    e_enreg = w & ~v;
    e_envec = w & v;
    if (w) begin
      e_res = d; e_dest = r; e_vf = v;
    end
  endtask

  task automatic tick();
    logic [127:0] word;
    @(posedge clk);
    e_enreg = 0; e_envec = 0;
    if (rst) begin
      m_pend = 0; m_q.delete();
      e_res = 0; e_dest = 0; e_vf = 0;
    end else if (!m_pend) begin
      if (valid_m) begin
        m_wreg = wreg_m; m_vf = VF_m; m_dest = R_V_dest_m;
        if (!rmem_m) commit(ALURes_m, wreg_m, VF_m, R_V_dest_m);
        else begin m_pend = 1; m_q.delete(); end
      end
    end else if (mem_rvalid) begin
      m_q.push_back(mem_rdata);
      if (!m_vf || m_q.size() == 4) begin
        word = 0;
        for (int i = 0; i < m_q.size(); i++) word[i*32 +: 32] = m_q[i];
        commit(word, m_wreg, m_vf, m_dest);
        m_pend = 0;
      end
    end
    e_stall = m_pend;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick();
    checks++;
    if ({ResRV2, R_V_dest3, VF3, EnReg, EnVec, stall} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h/%h/%b%b%b%b want all 0", ResRV2, R_V_dest3, VF3, EnReg, EnVec, stall);
    end
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = i[0]; mem_rdata = $urandom; tick();
      checks++;
      if (ResRV2 !== 0 || EnReg !== 0 || EnVec !== 0 || stall !== 0) begin
        failures++; $display("FAIL idle_rvalid cyc=%0d got res=%h en=%b%b stall=%b want 0", i, ResRV2, EnReg, EnVec, stall);
      end
    end
    mem_rvalid = 0;
  endtask

  task automatic test_alu_vector();
    valid_m = 1; wreg_m = 1; VF_m = 1; rmem_m = 0; R_V_dest_m = 5; ALURes_m = {32{4'hA}};
    tick(); valid_m = 0;
    checks++;
    if (EnVec !== 1 || EnReg !== 0 || ResRV2 !== {32{4'hA}} || R_V_dest3 !== 5 || VF3 !== 1) begin
      failures++; $display("FAIL alu_vec_commit got en=%b%b res=%h d=%0d vf=%b want en=01 res=A..A d=5 vf=1", EnReg, EnVec, ResRV2, R_V_dest3, VF3);
    end
    ALURes_m = $urandom; tick();
    checks++;
    if (EnVec !== 0 || ResRV2 !== {32{4'hA}} || R_V_dest3 !== 5) begin
      failures++; $display("FAIL alu_vec_hold got envec=%b res=%h d=%0d want 0/A..A/5", EnVec, ResRV2, R_V_dest3);
    end
  endtask

  task automatic test_scalar_load();
    logic [127:0] alu = {$urandom, $urandom, $urandom, $urandom};
    valid_m = 1; wreg_m = 1; VF_m = 0; rmem_m = 1; R_V_dest_m = 3; mem_rvalid = 1; mem_rdata = 32'h12345678;
    tick();
    rmem_m = 0; R_V_dest_m = 7; ALURes_m = alu; mem_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall !== 1 || EnReg !== 0 || EnVec !== 0) begin
        failures++; $display("FAIL sload_wait cyc=%0d got stall=%b en=%b%b want 1/00", i, stall, EnReg, EnVec);
      end
      if (i == 2) begin mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; end
      tick();
    end
    mem_rvalid = 0;
    checks++;
    if (EnReg !== 1 || EnVec !== 0 || stall !== 0 || ResRV2 !== 128'hDEADBEEF || R_V_dest3 !== 3 || VF3 !== 0) begin
      failures++; $display("FAIL sload_commit got en=%b%b stall=%b res=%h d=%0d want 10/0/DEADBEEF/3", EnReg, EnVec, stall, ResRV2, R_V_dest3);
    end
    tick(); valid_m = 0;
    checks++;
    if (EnReg !== 1 || ResRV2 !== alu || R_V_dest3 !== 7) begin
      failures++; $display("FAIL held_alu_accept got en=%b res=%h d=%0d want 1/%h/7", EnReg, ResRV2, R_V_dest3, alu);
    end
    tick();
    checks++;
    if (EnReg !== 0 || stall !== 0) begin
      failures++; $display("FAIL held_alu_done got en=%b stall=%b want 0/0", EnReg, stall);
    end
  endtask

  task automatic test_vector_load();
    logic [31:0] bd[5] = '{32'h11111111, 32'h22222222, 32'h0, 32'h33333333, 32'h44444444};
    logic        bv[5] = '{1, 1, 0, 1, 1};
    valid_m = 1; wreg_m = 1; VF_m = 1; rmem_m = 1; R_V_dest_m = 9;
    tick(); valid_m = 0;
    for (int i = 0; i < 5; i++) begin
      mem_rvalid = bv[i]; mem_rdata = bd[i]; tick();
      if (i < 4) begin
        checks++;
        if (EnVec !== 0 || EnReg !== 0 || stall !== 1) begin
          failures++; $display("FAIL vload_early cyc=%0d got en=%b%b stall=%b want 00/1", i, EnReg, EnVec, stall);
        end
      end
    end
    mem_rvalid = 0;
    checks++;
    if (EnVec !== 1 || EnReg !== 0 || stall !== 0 || ResRV2 !== 128'h44444444_33333333_22222222_11111111 || R_V_dest3 !== 9 || VF3 !== 1) begin
      failures++; $display("FAIL vload_commit got en=%b%b stall=%b res=%h d=%0d", EnReg, EnVec, stall, ResRV2, R_V_dest3);
    end
    tick();
    checks++;
    if (EnVec !== 0) begin failures++; $display("FAIL vload_pulse got envec=%b want 0", EnVec); end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] b[4];
    valid_m = 1; wreg_m = 1; VF_m = 1; rmem_m = 1; R_V_dest_m = 2;
    tick(); valid_m = 0;
    for (int i = 0; i < 2; i++) begin mem_rvalid = 1; mem_rdata = 32'hAAAA0001 + i; tick(); end
    mem_rvalid = 0; rst = 1; tick(); rst = 0;
    checks++;
    if ({ResRV2, R_V_dest3, VF3, EnReg, EnVec, stall} !== '0) begin
      failures++; $display("FAIL midload_reset got res=%h stall=%b en=%b%b want 0", ResRV2, stall, EnReg, EnVec);
    end
    valid_m = 1; R_V_dest_m = 6;
    tick(); valid_m = 0;
    for (int i = 0; i < 4; i++) begin
      b[i] = $urandom; mem_rvalid = 1; mem_rdata = b[i]; tick();
      checks++;
      if (EnVec !== (i == 3)) begin
        failures++; $display("FAIL midload_reload beat=%0d got envec=%b want %b", i, EnVec, i == 3);
      end
    end
    mem_rvalid = 0;
    checks++;
    if (ResRV2 !== {b[3], b[2], b[1], b[0]} || R_V_dest3 !== 6) begin
      failures++; $display("FAIL midload_data got %h d=%0d want %h d=6", ResRV2, R_V_dest3, {b[3], b[2], b[1], b[0]});
    end
  endtask

  task automatic test_no_write();
    valid_m = 1; wreg_m = 0; rmem_m = 0; VF_m = $urandom; ALURes_m = $urandom;
    tick();
    checks++;
    if (EnReg !== 0 || EnVec !== 0 || stall !== 0) begin
      failures++; $display("FAIL store_like got en=%b%b stall=%b want 00/0", EnReg, EnVec, stall);
    end
    rmem_m = 1; VF_m = 0;
    tick(); valid_m = 0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = (i == 2); mem_rdata = $urandom;
      checks++;
      if (stall !== 1 || EnReg !== 0 || EnVec !== 0) begin
        failures++; $display("FAIL nowrite_load_wait cyc=%0d got stall=%b en=%b%b want 1/00", i, stall, EnReg, EnVec);
      end
      tick();
    end
    mem_rvalid = 0;
    checks++;
    if (stall !== 0 || EnReg !== 0 || EnVec !== 0) begin
      failures++; $display("FAIL nowrite_load_done got stall=%b en=%b%b want 0/00", stall, EnReg, EnVec);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(63) == 0);
      valid_m = $urandom; wreg_m = ($urandom_range(3) != 0); rmem_m = ($urandom_range(4) < 2);
      VF_m = $urandom; R_V_dest_m = $urandom;
      ALURes_m = {$urandom, $urandom, $urandom, $urandom};
      mem_rvalid = $urandom; mem_rdata = $urandom;
      tick();
      checks++;
      if (stall !== e_stall || EnReg !== e_enreg || EnVec !== e_envec) begin
        failures++; $display("FAIL rand_ctrl n=%0d got stall=%b en=%b%b want %b/%b%b", n, stall, EnReg, EnVec, e_stall, e_enreg, e_envec);
      end
      if (e_enreg || e_envec) begin
        checks++;
        if (ResRV2 !== e_res || R_V_dest3 !== e_dest || VF3 !== e_vf) begin
          failures++; $display("FAIL rand_data n=%0d got %h d=%0d vf=%b want %h d=%0d vf=%b", n, ResRV2, R_V_dest3, VF3, e_res, e_dest, e_vf);
        end
      end
    end
    rst = 0; valid_m = 0; mem_rvalid = 0;
  endtask

  initial begin
    test_reset();
    test_alu_vector();
    test_scalar_load();
    test_vector_load();
    test_reset_mid_load();
    test_no_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
